uart_tx_engine: RTL

//   Serial transmitter at the far end of the CPU's UART write port (DataIn/DataInValid/DataInReady).

---
 rtl/uart_tx_engine.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// UART transmitter: 1 start / 8 data (LSB first) / 1 stop, one byte per valid/ready handshake.
// Optional even-parity symbol after D7 when UART_TX_PARITY_EN is defined.
module uart_tx_engine #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SOut
);

    localparam int N     = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam state_t AFTER_DATA = S_STOP;
`endif

    state_t           state_q, state_next;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic [2:0]       bit_idx_q, bit_idx_next;
    logic [9:0]       shreg_q, shreg_next;
    logic             ready_d, sout_d;
    logic             handshake, sym_done;

    assign handshake = DataInValid & DataInReady;
    assign sym_done  = (cnt_q == CNT_LAST);

    // Outputs are registered from the next-state values so SOut and
    // DataInReady change on the same edge as the state they describe.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '1;
            DataInReady <= 1'b0;
            SOut        <= 1'b1;
        end else begin
            state_q     <= state_next;
            cnt_q       <= cnt_next;
            bit_idx_q   <= bit_idx_next;
            shreg_q     <= shreg_next;
            DataInReady <= ready_d;
            SOut        <= sout_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge CLK) begin
        if (!reset_n)
            parity_q <= 1'b0;
        else if (handshake)
            parity_q <= ^DataIn;
    end
`endif

    // NOTE: every comb output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next   = state_q;
        cnt_next     = cnt_q;
        bit_idx_next = bit_idx_q;
        shreg_next   = shreg_q;
        if (state_q != S_IDLE)
            cnt_next = sym_done ? '0 : cnt_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    state_next   = S_START;
                    shreg_next   = {1'b1, DataIn, 1'b0};
                    cnt_next     = '0;
                    bit_idx_next = '0;
                end
            end
            S_START: begin
                if (sym_done) begin
                    state_next = S_DATA;
                    shreg_next = {1'b1, shreg_q[9:1]};
                end
            end
            S_DATA: begin
                if (sym_done) begin
                    shreg_next   = {1'b1, shreg_q[9:1]};
                    bit_idx_next = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7)
                        state_next = AFTER_DATA;
                end
            end
            S_PARITY: begin
                if (sym_done)
                    state_next = S_STOP;
            end
            S_STOP: begin
                if (sym_done)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Shift register bit 0 is always the symbol on the line; after D7 it holds the stop bit.
    always_comb begin
        ready_d = (state_next == S_IDLE);
        sout_d  = shreg_next[0];
        if (state_next == S_IDLE)
            sout_d = 1'b1;
`ifdef UART_TX_PARITY_EN
        if (state_next == S_PARITY)
            sout_d = parity_q;
`endif
    end

endmodule
